// File: rtl/reg_file_dump_engine.sv
// ============================================================================
// reg_file_dump_engine: walks the register file two registers per beat and
// streams each captured pair out on a valid/ready interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_dump_engine #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_reg_1,
  output logic [ADDR_WIDTH-1:0] rd_reg_2,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  if ((NUM_REGS < 2) || ((NUM_REGS % 2) != 0) || (NUM_REGS > (1 << ADDR_WIDTH))) begin : g_param_check
    $error("reg_file_dump_engine: NUM_REGS must be even, >= 2 and <= 2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(NUM_REGS - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  w_is_last;
  logic                  w_handshake;

  assign w_is_last   = (r_idx == c_LAST_IDX);
  assign w_handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // abort outranks both a pending start and a simultaneous handshake
  always_comb begin
    w_state_nxt = r_state;
    rd_reg_1    = '0;
    rd_reg_2    = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_READ;
      end
      S_READ: begin
        busy        = 1'b1;
        rd_reg_1    = r_idx;
        rd_reg_2    = r_idx + ADDR_WIDTH'(1);
        w_state_nxt = abort ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_handshake) begin
          w_state_nxt = w_is_last ? S_IDLE : S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data_1 <= '0;
      out_data_2 <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) r_idx <= '0;
        end
        S_READ: begin
          // read data is combinational, so this edge captures the pre-write value
          if (!abort) begin
            out_data_1 <= rd_data_1;
            out_data_2 <= rd_data_2;
            out_idx    <= r_idx;
            out_valid  <= 1'b1;
            out_last   <= w_is_last;
          end
        end
        S_SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (w_handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (w_is_last) begin
              done <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_WIDTH'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_dump_engine.sv
// ============================================================================
// tb_reg_file_dump_engine: register-file stand-in, cycle model and directed
// scenarios for reg_file_dump_engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_dump_engine;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, out_ready;
  logic [AW-1:0] rd_reg_1, rd_reg_2, out_idx;
  logic [DW-1:0] rd_data_1, rd_data_2, out_data_1, out_data_2;
  logic          out_valid, out_last, busy, done;

  logic          we, preload;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [NR];

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  reg_file_dump_engine #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // register file: posedge write, combinational read, x0 hardwired to zero
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NR; i++) mem[i] <= (i == 0) ? '0 : DW'(32'hA000_0000 + i);
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end
  assign rd_data_1 = (rd_reg_1 == '0) ? '0 : mem[rd_reg_1];
  assign rd_data_2 = (rd_reg_2 == '0) ? '0 : mem[rd_reg_2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rf(input int i);
    return (i == 0) ? '0 : mem[i];
  endfunction

  // Model: what the stream must look like given the start/abort/ready history
  bit            m_active = 0, m_valid = 0, m_done = 0, m_last = 0;
  int            exp_idx = 0;
  logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_reg_2", rd_reg_2, 0);
      m_active = 0; m_valid = 0; m_done = 0;
    end else begin
      chk("busy", busy, m_active);
      chk("out_valid", out_valid, m_valid);
      chk("done", done, m_done);
      chk("rd_reg_1", rd_reg_1, (m_active && !m_valid) ? exp_idx : 0);
      chk("rd_reg_2", rd_reg_2, (m_active && !m_valid) ? exp_idx + 1 : 0);
      if (m_valid) begin
        chk("out_idx", out_idx, exp_idx);
        chk("out_data_1", out_data_1, exp_d1);
        chk("out_data_2", out_data_2, exp_d2);
        chk("out_last", out_last, m_last);
      end
      m_done = 0;
      if (m_active && abort) begin
        m_active = 0; m_valid = 0;
      end else if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_valid = 0; exp_idx = 0;
        end
      end else if (!m_valid) begin
        m_valid = 1;
        exp_d1  = rf(exp_idx);
        exp_d2  = rf(exp_idx + 1);
        m_last  = (exp_idx == NR - 2);
      end else if (out_ready) begin
        m_valid = 0;
        if (exp_idx == NR - 2) begin
          m_active = 0; m_done = 1;
        end else begin
          exp_idx += 2;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_beat(input int idx, output int n);
    n = 0;
    while (!(out_valid && out_idx == AW'(idx)) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk($sformatf("beat_timeout_%0d", idx), 0, 1);
  endtask

  task automatic wait_done;
    int g = 0;
    while (!done && g < 200) begin
      step();
      g++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, t0, beats;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; preload = 1'b0;
    #1 rst_n = 1'b0;
    preload = 1'b1;
    step(); step();
    preload = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_data_1", out_data_1, 0);
    chk("reset_rd_reg_1", rd_reg_1, 0);
    rst_n = 1'b1;

    // attempted write to x0
    we = 1'b1; waddr = '0; wdata = 32'hFFFF_FFFF;
    step();
    we = 1'b0;

    // full dump with sink always ready
    start = 1'b1; step(); start = 1'b0; t0 = edge_n;
    wait_beat(0, n);
    chk("t1_first_latency", n, 1);
    chk("t1_b0_d1_x0", out_data_1, 32'h0);
    chk("t1_b0_d2", out_data_2, 32'hA000_0001);
    chk("t1_b0_last", out_last, 0);
    wait_beat(30, n);
    chk("t1_b15_d1", out_data_1, 32'hA000_001E);
    chk("t1_b15_d2", out_data_2, 32'hA000_001F);
    chk("t1_b15_last", out_last, 1);
    wait_done();
    chk("t1_done_edge", edge_n - t0, 32);

    // backpressure on beat idx 4
    step();
    start = 1'b1; step(); start = 1'b0; t0 = edge_n;
    wait_beat(4, n);
    out_ready = 1'b0;
    repeat (5) step();
    chk("t2_held_valid", out_valid, 1);
    chk("t2_held_idx", out_idx, 4);
    chk("t2_held_d1", out_data_1, 32'hA000_0004);
    out_ready = 1'b1;
    wait_done();
    chk("t2_done_edge", edge_n - t0, 37);

    // write to x6 on the beat-3 capture edge, then re-dump started on done
    step();
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    we = 1'b1; waddr = AW'(6); wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0;
    chk("t3_b3_valid", out_valid, 1);
    chk("t3_b3_idx", out_idx, 6);
    chk("t3_b3_old", out_data_1, 32'hA000_0006);
    wait_done();
    start = 1'b1; step(); start = 1'b0;
    wait_beat(6, n);
    chk("t3_b3_new", out_data_1, 32'hDEAD_BEEF);
    wait_done();

    // abort during SEND of idx 10, racing a handshake
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_beat(10, n);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    repeat (3) step();
    chk("t4_no_done", done, 0);
    start = 1'b1; step(); start = 1'b0;
    wait_beat(0, n);
    chk("t4_restart_latency", n, 1);
    chk("t4_restart_idx", out_idx, 0);
    wait_done();

    // async reset mid-READ
    step();
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    chk("t5_pre_rd_reg_1", rd_reg_1, 8);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_rd_reg_1", rd_reg_1, 0);
    chk("t5_rst_rd_reg_2", rd_reg_2, 0);
    chk("t5_rst_out_idx", out_idx, 0);
    chk("t5_rst_out_d1", out_data_1, 0);
    chk("t5_rst_last", out_last, 0);
    step();
    rst_n = 1'b1;
    step();

    // start pulses while busy are ignored
    start = 1'b1; step(); start = 1'b0; t0 = edge_n;
    beats = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      start = (k == 1 || k == 6 || k == 13);
      if (out_valid && out_ready) beats++;
      step();
    end
    start = 1'b0;
    chk("t5_done_seen", done, 1);
    chk("t5_beats", beats, 16);
    chk("t5_done_edge", edge_n - t0, 32);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
